// File: rtl/fifo1.sv
// fifo1: single-clock first-word-fall-through FIFO with registered full/empty flags
module fifo1 #(
  parameter int DSIZE = 128,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             rrst_n,
  input  logic             rclk,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
);
  logic [DSIZE-1:0] mem_q [2**ASIZE];
  logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             wfull_q, wfull_d, rempty_q, rempty_d;
  logic [1:0]       rst_sync_q;
  logic             rst_raw_n, rst_n, we, re;
  logic             unused_rclk;
  assign unused_rclk = rclk;
  assign rst_raw_n   = wrst_n & rrst_n;
  assign rst_n       = rst_sync_q[1];
  assign we          = winc & ~wfull_q & rst_n;
  assign re          = rinc & ~rempty_q & rst_n;
  assign rdata       = mem_q[rptr_q[ASIZE-1:0]];
  assign wfull       = wfull_q;
  assign rempty      = rempty_q;
  // reset asserts immediately, releases after two wclk edges
  always_ff @(posedge wclk or negedge rst_raw_n)
    if (!rst_raw_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  // storage array, written only on an accepted write
  always_ff @(posedge wclk)
    if (we) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
  // next pointers and flags derived from them so flags are exact one cycle later
  always_comb begin
    wptr_d   = wptr_q + {{ASIZE{1'b0}}, we};
    rptr_d   = rptr_q + {{ASIZE{1'b0}}, re};
    rempty_d = wptr_d == rptr_d;
    wfull_d  = wptr_d == {~rptr_d[ASIZE], rptr_d[ASIZE-1:0]};
  end
  // pointer and flag registers
  always_ff @(posedge wclk or negedge rst_n)
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      wfull_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      wfull_q  <= wfull_d;
    end
endmodule

// File: tb/tb_fifo1.sv
// tb_fifo1: directed scoreboard bench for fifo1
module tb_fifo1;
  localparam int DSIZE = 128;
  localparam int DEPTH = 16;
  logic             wclk = 1'b0, rclk = 1'b0;
  logic             wrst_n, rrst_n, winc, rinc;
  logic [DSIZE-1:0] wdata, rdata;
  logic             wfull, rempty;
  logic [DSIZE-1:0] q[$];
  int               checks = 0, errors = 0;

  fifo1 #(.DSIZE(DSIZE), .ASIZE(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .rrst_n(rrst_n), .rclk(rclk),
    .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata), .wfull(wfull), .rempty(rempty)
  );

  always #5 wclk = ~wclk;
  always #7 rclk = ~rclk;

  task automatic chk(input string tag, input logic [DSIZE-1:0] obs, input logic [DSIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_rempty"}, DSIZE'(rempty), DSIZE'(q.size() == 0));
    chk({tag, "_wfull"},  DSIZE'(wfull),  DSIZE'(q.size() == DEPTH));
    if (q.size() > 0) chk({tag, "_rdata"}, rdata, q[0]);
  endtask

  task automatic cyc(input logic w, input logic r, input logic [DSIZE-1:0] d, input string tag);
    bit we, re;
    winc  = w;
    rinc  = r;
    wdata = d;
    we = w && q.size() < DEPTH;
    re = r && q.size() > 0;
    @(posedge wclk);
    if (re) void'(q.pop_front());
    if (we) q.push_back(d);
    @(negedge wclk);
    check_state(tag);
  endtask

  initial begin
    wrst_n = 1'b0; rrst_n = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;
    @(negedge wclk);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, "in_reset");
    wrst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, "post_reset");
    cyc(1, 0, 'h1, "single_wr");
    cyc(0, 1, '0, "single_rd");
    for (int i = 1; i <= 16; i++) cyc(1, 0, DSIZE'(i), "fill");
    cyc(1, 0, 'h11, "overflow");
    for (int i = 0; i < 16; i++) cyc(0, 1, '0, "drain");
    cyc(0, 1, '0, "underflow");
    for (int i = 1; i <= 64; i++) cyc(1, i >= 4, DSIZE'(i), "wrap");
    while (q.size() > 0) cyc(0, 1, '0, "wrap_drain");
    for (int i = 0; i < 8; i++) cyc(1, 0, DSIZE'(32'h100 + i), "fill8");
    for (int i = 0; i < 5; i++) cyc(1, 1, DSIZE'(32'h200 + i), "simul8");
    chk("occupancy8", DSIZE'(q.size()), DSIZE'(8));
    for (int i = 0; i < 8; i++) cyc(1, 0, DSIZE'(32'h300 + i), "fill16");
    cyc(1, 1, 'h3FF, "simul_full");
    chk("full_after_simul", DSIZE'(wfull), DSIZE'(0));
    cyc(1, 1, 'h400, "simul_refill");
    while (q.size() > 0) cyc(0, 1, '0, "drain2");
    cyc(1, 1, 'h500, "simul_empty");
    cyc(0, 1, '0, "drain3");
    for (int i = 0; i < 5; i++) cyc(1, 0, DSIZE'(32'h600 + i), "fill5");
    #2 rrst_n = 1'b0;
    #1;
    q.delete();
    chk("async_rst_rempty", DSIZE'(rempty), DSIZE'(1));
    chk("async_rst_wfull", DSIZE'(wfull), DSIZE'(0));
    @(negedge wclk);
    check_state("rst_hold");
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, "rst_release");
    cyc(1, 0, 'hAA, "after_rst_wr");
    chk("after_rst_aa", rdata, DSIZE'('hAA));
    cyc(0, 1, '0, "after_rst_rd");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo1.md
FIFO1 -- requirements
Module: fifo1

Interface
REQ-001 Parameter DSIZE, default 128, data word width in bits.
REQ-002 Parameter ASIZE, default 4, address width; depth SHALL be 2**ASIZE words (16 words by default).
REQ-003 The block has one clock, and its reset is asynchronous and active-low.
REQ-004 wclk  input  1  sole clock; all state updates on the rising edge.
REQ-005 wrst_n  input  1  asynchronous active-low reset.
REQ-006 rrst_n  input  1  asynchronous active-low reset, ANDed with wrst_n; either low resets the whole block.
REQ-007 rclk  input  1  reserved for port compatibility; SHALL have no effect on behaviour.
REQ-008 wdata  input  DSIZE  write data, sampled at the wclk edge when a write is accepted.
REQ-009 winc  input  1  write request.
REQ-010 rinc  input  1  read request (pop).
REQ-011 rdata  output  DSIZE  oldest stored word (first-word-fall-through).
REQ-012 wfull  output  1  FIFO holds 2**ASIZE words.
REQ-013 rempty  output  1  FIFO holds 0 words.

Function
REQ-014 Storage: 2**ASIZE x DSIZE register array; contents not reset.
REQ-015 Pointers:
- wptr and rptr are ASIZE+1-bit binary counters.
- The low ASIZE bits address the array.
- The MSB is the wrap bit.
REQ-016 Write accept: winc=1 and wfull=0 at a wclk edge stores wdata at mem[wptr[ASIZE-1:0]] and increments wptr modulo 2**(ASIZE+1).
REQ-017 Read accept: rinc=1 and rempty=0 at a wclk edge increments rptr modulo 2**(ASIZE+1).
REQ-018 Blocked requests: winc while wfull=1, or rinc while rempty=1, SHALL be ignored with no state change and no data corruption.
REQ-019 rdata SHALL combinationally equal mem[rptr[ASIZE-1:0]].
- Valid whenever rempty=0, with zero read latency.
- Undefined while rempty=1.
REQ-020 rempty and wfull are registered and computed from next-state pointers, so they are exact in the cycle after the causing edge.
- rempty = (next wptr == next rptr).
- wfull = (next wptr == next rptr with MSB inverted).
REQ-021 Latency: a word written at edge N is visible on rdata, with rempty=0, after edge N when the FIFO was empty.
REQ-022 Simultaneous accepted read and write: occupancy unchanged, flags unchanged, both pointers advance.
REQ-023 Simultaneous requests when full: read accepted, write dropped, and wfull=0 next cycle.
REQ-024 Simultaneous requests when empty: write accepted, read dropped, and rempty=0 next cycle.
REQ-025 Wrap-around: pointer rollover SHALL preserve strict FIFO order indefinitely.

Reset
REQ-026 Reset asserts asynchronously, independent of wclk.
REQ-027 Reset deasserts synchronously via a 2-flop synchronizer on wclk.
REQ-028 During reset: wptr=0, rptr=0, rempty=1, wfull=0; winc and rinc ignored.
REQ-029 Reset mid-operation discards all stored words immediately.

Verification
REQ-030 Reset: hold wrst_n=0 for 3 cycles, then release -> rempty=1, wfull=0; winc/rinc held 0 leaves flags unchanged.
REQ-031 Single word: write 0x1 -> next cycle rempty=0 and rdata=0x1; one rinc -> rempty=1.
REQ-032 Fill and drain:
- Write 0x1..0x10 with rinc=0 -> wfull=1 after the 16th write.
- A 17th write of 0x11 is ignored.
- Reading 16 words returns 0x1..0x10 in order, then rempty=1.
REQ-033 Wrap: stream 0x1..0x40 with winc=1 continuously and rinc=1 from the 4th cycle -> output sequence 0x1..0x40 in order, no loss, wfull never asserted.
REQ-034 Simultaneous requests:
- At 8 entries, winc=rinc=1 for 5 cycles -> occupancy stays 8 and flags stay 0.
- At full, winc=rinc=1 -> one word read, write dropped, wfull=0.
REQ-035 Reset mid-operation: with 5 entries, pulse rrst_n=0 asynchronously -> rempty=1 and wfull=0 immediately; the next write 0xAA reads back as 0xAA.
